// File: rtl/timer_pkg.sv
// Shared definitions for the millisecond timing chain: timer state encoding,
// the millisecond divide ratio and the default countdown width.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

    // 100 MHz clock cycles per millisecond tick, shared with the ms counter
    localparam int MS_CYCLES = 100000;

    // Default width of the load value and remaining count, in ms
    localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/ms_countdown_timer.sv
// Programmable millisecond countdown timer. Counts down one step per ms_tick
// while running, pulses expired on reaching zero, optionally auto-reloads,
// and gates the upstream millisecond counter through cnt_en.
module ms_countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ms_tick,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic             auto_reload,
    output logic             cnt_en,
    output logic [WIDTH-1:0] remaining,
    output logic             expired,
    output logic             done,
    output logic [EXP_W-1:0] exp_count,
    output logic [1:0]       state_o
);

    timer_state_t     state;
    logic [WIDTH-1:0] reload_reg;

    // State and datapath update; commands resolve in the order
    // clear, load, pause, start, ms_tick, and a command that does not apply
    // in the current state lets the next one through
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            remaining  <= '0;
            reload_reg <= '0;
            exp_count  <= '0;
            expired    <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (clear) begin
                state     <= IDLE;
                remaining <= '0;
                exp_count <= '0;
            end else if (load && (state != RUN)) begin
                reload_reg <= load_val;
                remaining  <= load_val;
                state      <= IDLE;
            end else if (pause && (state == RUN)) begin
                state <= PAUSE;
            end else if (start && ((state == IDLE) || (state == PAUSE)) &&
                         (remaining != '0)) begin
                state <= RUN;
            end else if (ms_tick && (state == RUN)) begin
                if (remaining > WIDTH'(1)) begin
                    remaining <= remaining - WIDTH'(1);
                end else if (auto_reload && (reload_reg != '0)) begin
                    remaining <= reload_reg;
                    expired   <= 1'b1;
                    exp_count <= exp_count + EXP_W'(1);
                end else begin
                    remaining <= '0;
                    state     <= DONE;
                    expired   <= 1'b1;
                    exp_count <= exp_count + EXP_W'(1);
                end
            end
        end
    end

    // Status outputs decoded straight from the state register
    always_comb begin
        cnt_en  = (state == RUN);
        done    = (state == DONE);
        state_o = state;
    end

endmodule

// File: tb/tb_ms_countdown_timer.sv
// Directed testbench for ms_countdown_timer: reset, countdown, auto-reload,
// pause priority, command ignore rules and expiry counter wrap.
module tb_ms_countdown_timer;

    localparam int WIDTH = 16;
    localparam int EXP_W = 8;

    logic             clk;
    logic             rst_n;
    logic             ms_tick;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic             clear;
    logic             auto_reload;
    logic             cnt_en;
    logic [WIDTH-1:0] remaining;
    logic             expired;
    logic             done;
    logic [EXP_W-1:0] exp_count;
    logic [1:0]       state_o;

    int compared   = 0;
    int mismatched = 0;

    ms_countdown_timer #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ms_tick     (ms_tick),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .pause       (pause),
        .clear       (clear),
        .auto_reload (auto_reload),
        .cnt_en      (cnt_en),
        .remaining   (remaining),
        .expired     (expired),
        .done        (done),
        .exp_count   (exp_count),
        .state_o     (state_o)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive one cycle of command pulses, then settle just past the clock edge
    task automatic applyStimulus(input logic ld, input logic [WIDTH-1:0] lv,
                                 input logic st, input logic pa,
                                 input logic cl, input logic tk);
        @(negedge clk);
        load     = ld;
        load_val = lv;
        start    = st;
        pause    = pa;
        clear    = cl;
        ms_tick  = tk;
        @(posedge clk);
        #1;
        load    = 1'b0;
        start   = 1'b0;
        pause   = 1'b0;
        clear   = 1'b0;
        ms_tick = 1'b0;
    endtask

    // Let the design run with no commands for n cycles
    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Main directed sequence
    initial begin
        int exp_pulses;
        int done_seen;

        rst_n       = 1'b0;
        ms_tick     = 1'b0;
        load        = 1'b0;
        load_val    = '0;
        start       = 1'b0;
        pause       = 1'b0;
        clear       = 1'b0;
        auto_reload = 1'b0;

        // Reset held for two cycles while inputs toggle randomly
        repeat (2) begin
            @(negedge clk);
            ms_tick     = 1'($urandom_range(0, 1));
            load        = 1'($urandom_range(0, 1));
            load_val    = WIDTH'($urandom_range(1, 65535));
            start       = 1'($urandom_range(0, 1));
            pause       = 1'($urandom_range(0, 1));
            clear       = 1'($urandom_range(0, 1));
            auto_reload = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        checkOutput("rst_remaining", 32'(remaining), 0);
        checkOutput("rst_state", 32'(state_o), 0);
        checkOutput("rst_cnt_en", 32'(cnt_en), 0);
        checkOutput("rst_expired", 32'(expired), 0);
        checkOutput("rst_exp_count", 32'(exp_count), 0);
        checkOutput("rst_done", 32'(done), 0);
        @(negedge clk);
        rst_n       = 1'b1;
        ms_tick     = 1'b0;
        load        = 1'b0;
        load_val    = '0;
        start       = 1'b0;
        pause       = 1'b0;
        clear       = 1'b0;
        auto_reload = 1'b0;
        idleCycles(1);

        // Basic countdown from 3
        applyStimulus(1'b1, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("basic_loaded", 32'(remaining), 3);
        checkOutput("basic_idle", 32'(state_o), 0);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("basic_run", 32'(state_o), 1);
        checkOutput("basic_cnt_en", 32'(cnt_en), 1);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("basic_tick1", 32'(remaining), 2);
        idleCycles(4);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("basic_tick2", 32'(remaining), 1);
        checkOutput("basic_no_exp_early", 32'(expired), 0);
        idleCycles(4);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("basic_tick3", 32'(remaining), 0);
        checkOutput("basic_expired", 32'(expired), 1);
        checkOutput("basic_done", 32'(done), 1);
        checkOutput("basic_state_done", 32'(state_o), 3);
        checkOutput("basic_cnt_en_off", 32'(cnt_en), 0);
        checkOutput("basic_exp_count", 32'(exp_count), 1);
        idleCycles(1);
        checkOutput("basic_expired_width", 32'(expired), 0);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("done_ignores_start", 32'(state_o), 3);

        // Auto-reload with a period of two ticks
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("clear_exp_count", 32'(exp_count), 0);
        auto_reload = 1'b1;
        applyStimulus(1'b1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_pulses = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            if (expired) exp_pulses++;
            checkOutput("ar_remaining", 32'(remaining), (i % 2 == 1) ? 2 : 1);
            checkOutput("ar_state", 32'(state_o), 1);
            idleCycles(2);
        end
        checkOutput("ar_pulses", 32'(exp_pulses), 3);
        checkOutput("ar_exp_count", 32'(exp_count), 3);

        // Pause wins over a simultaneous tick
        auto_reload = 1'b0;
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("pause_remaining", 32'(remaining), 5);
        checkOutput("pause_state", 32'(state_o), 2);
        checkOutput("pause_cnt_en", 32'(cnt_en), 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("pause_ticks_ignored", 32'(remaining), 5);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("resume_state", 32'(state_o), 1);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("resume_tick", 32'(remaining), 4);

        // Load is ignored while running
        applyStimulus(1'b1, 16'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("run_load_ignored", 32'(remaining), 4);
        checkOutput("run_load_state", 32'(state_o), 1);

        // Clear beats load in the same cycle
        applyStimulus(1'b1, 16'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("clr_load_remaining", 32'(remaining), 0);
        checkOutput("clr_load_state", 32'(state_o), 0);

        // Start with nothing to count stays idle
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("start_zero_state", 32'(state_o), 0);
        checkOutput("start_zero_cnt_en", 32'(cnt_en), 0);

        // Expiry counter wraps after 256 expiries
        auto_reload = 1'b1;
        applyStimulus(1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        done_seen = 0;
        for (int i = 0; i < 257; i++) begin
            applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            if (done) done_seen++;
            if (i == 254) checkOutput("wrap_255", 32'(exp_count), 255);
            if (i == 255) checkOutput("wrap_zero", 32'(exp_count), 0);
        end
        checkOutput("wrap_exp_count", 32'(exp_count), 1);
        checkOutput("wrap_remaining", 32'(remaining), 1);
        checkOutput("wrap_state", 32'(state_o), 1);
        checkOutput("wrap_no_done", 32'(done_seen), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
